// File: rtl/down_counter_pkg.sv
// Shared definitions for the down_counter block: state encoding and
// default parameter values.
package down_counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dc_state_t;

    localparam int DC_DEF_WIDTH = 16;
    localparam int DC_DEF_LIMIT = 25;

endpackage : down_counter_pkg

// File: rtl/down_counter.sv
// Loadable down-counter with one-shot / periodic auto-reload and a
// combinational underflow strobe at the terminal (count == 0) cycle.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | stopped; count frozen; start reloads from reload_q
// ST_RUN  | counting down on en; terminal cycle reloads or stops
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DC_DEF_WIDTH,
    parameter int LIMIT = DC_DEF_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             periodic,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             unf
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    dc_state_t        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             unf_d;

    // Next-state and strobe logic; priority is load, terminal, decrement, hold.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        unf_d    = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        count_d = reload_q;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        if (count_q == '0) begin
                            // Terminal cycle: periodic is only looked at here.
                            unf_d = 1'b1;
                            if (periodic) begin
                                count_d = reload_q;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; reset forces idle with the reload value at LIMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= LIMIT_W;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_RUN);
    assign unf   = unf_d;

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter.
module tb_down_counter;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             periodic;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             unf;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;

    down_counter #(.WIDTH(WIDTH), .LIMIT(25)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .periodic   (periodic),
        .count      (count),
        .busy       (busy),
        .unf        (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_state(input string tag, input int c, input int b, input int u);
        check({tag, ".count"}, int'(count), c);
        check({tag, ".busy"},  int'(busy),  b);
        check({tag, ".unf"},   int'(unf),   u);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; load_value = '0;
        start = 1'b0; periodic = 1'b0;
        #3;
        check_state("reset", 0, 0, 0);

        // load/start during reset are ignored
        load = 1'b1; load_value = 16'd9; start = 1'b1;
        tick(); tick();
        check_state("rst_ignore", 0, 0, 0);
        load = 1'b0; start = 1'b0;
        rst = 1'b0;
        tick();
        check_state("post_rst", 0, 0, 0);

        // Periodic count from LIMIT
        periodic = 1'b1; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        settle();
        check_state("per_start", 25, 1, 0);
        for (int k = 24; k >= 0; k--) begin
            tick();
            check($sformatf("per_cnt%0d", k), int'(count), k);
            check($sformatf("per_unf%0d", k), int'(unf), (k == 0) ? 1 : 0);
        end
        tick();
        check_state("per_wrap", 25, 1, 0);
        cycles = 1;
        while (unf !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        check("per_period", cycles, 26);

        // One-shot from load 3
        periodic = 1'b0; load = 1'b1; load_value = 16'd3;
        tick();
        load = 1'b0;
        settle();
        check_state("os_load", 3, 1, 0);
        tick(); check_state("os_2", 2, 1, 0);
        tick(); check_state("os_1", 1, 1, 0);
        tick(); check_state("os_0", 0, 1, 1);
        tick(); check_state("os_idle", 0, 0, 0);
        tick(); check_state("os_hold", 0, 0, 0);

        // start reuses the reload register (3)
        start = 1'b1;
        tick();
        start = 1'b0;
        settle();
        check_state("restart", 3, 1, 0);

        // Enable gating and start ignored in RUN
        load = 1'b1; load_value = 16'd5;
        tick();
        load = 1'b0;
        settle();
        check_state("en_5", 5, 1, 0);
        tick(); check_state("en_4", 4, 1, 0);
        en = 1'b0; start = 1'b1;
        settle();
        check("en_off_unf", int'(unf), 0);
        tick();
        start = 1'b0;
        settle();
        check_state("en_hold", 4, 1, 0);
        en = 1'b1;
        tick(); check_state("en_3", 3, 1, 0);

        // load beats underflow on the terminal cycle
        tick(); tick(); tick();
        check_state("term_0", 0, 1, 1);
        load = 1'b1; load_value = 16'd7;
        settle();
        check("load_unf", int'(unf), 0);
        tick();
        load = 1'b0;
        settle();
        check_state("load_term", 7, 1, 0);

        // Asynchronous reset mid-count
        load = 1'b1; load_value = 16'd12;
        tick();
        load = 1'b0;
        tick(); tick();
        check_state("pre_rst", 10, 1, 0);
        rst = 1'b1;
        #2;
        check_state("async_rst", 0, 0, 0);
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        settle();
        check_state("rst_restart", 25, 1, 0);

        // Reload of 0 in periodic mode strobes every enabled cycle
        periodic = 1'b1; load = 1'b1; load_value = 16'd0;
        tick();
        load = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) begin
            check_state($sformatf("zero%0d", i), 0, 1, 1);
            tick();
        end
        en = 1'b0;
        settle();
        check_state("zero_en_off", 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule : tb_down_counter
